// File: rtl/calc_sequencer.sv
// calc_sequencer: sequencing controller for a small calculator built around a
// single shared N-bit adder/subtractor. Performs one-cycle ADD/SUB and an
// N-cycle unsigned shift-and-add MUL that reuses the same adder every cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   request strobe, accepted only in IDLE or DONE
//   op[1:0]  in   00 ADD, 01 SUB, 10 MUL, 11 NOP
//   a, b     in   operands, captured on acceptance
//   busy     out  high while an ADD/SUB or MUL is in progress
//   done     out  one-cycle completion pulse
//   result   out  last completed result (2N bits), held until next completion
//   overflow out  signed overflow of the last ADD/SUB, 0 otherwise
module calc_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   result,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDSUB = 2'd1,
    MUL    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             op_sub;

  // Shared adder operands
  logic [N-1:0]     add_x;
  logic [N-1:0]     add_y;
  logic             add_n;
  logic [N-1:0]     y_eff;
  logic [N-1:0]     add_s;
  logic             add_c;
  logic             add_ovf;

  // Next shift-and-add register contents
  logic [N-1:0]     acc_next;
  logic [N-1:0]     q_next;

  // Adder input steering; IDLE/DONE tie to captured operands so the adder is deterministic
  always_comb begin
    add_x = a_reg;
    add_y = q_reg;
    add_n = 1'b0;
    case (state)
      ADDSUB: begin
        add_x = a_reg;
        add_y = q_reg;
        add_n = op_sub;
      end
      MUL: begin
        add_x = acc;
        add_y = q_reg[0] ? a_reg : '0;
        add_n = 1'b0;
      end
      default: ;
    endcase
  end

  // The single adder/subtractor: subtract is x + ~y + 1
  always_comb begin
    y_eff            = add_n ? ~add_y : add_y;
    {add_c, add_s}   = {1'b0, add_x} + {1'b0, y_eff} + (N+1)'(add_n);
    add_ovf          = (add_x[N-1] == y_eff[N-1]) && (add_s[N-1] != add_x[N-1]);
    acc_next         = {add_c, add_s[N-1:1]};
    q_next           = {add_s[0], q_reg[N-1:1]};
  end

  // Controller state, operand registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      a_reg    <= '0;
      q_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      op_sub   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg  <= a;
            q_reg  <= b;
            acc    <= '0;
            cnt    <= '0;
            op_sub <= op[0];
            unique case (op)
              2'b00, 2'b01: begin
                state <= ADDSUB;
                busy  <= 1'b1;
                done  <= 1'b0;
              end
              2'b10: begin
                state <= MUL;
                busy  <= 1'b1;
                done  <= 1'b0;
              end
              2'b11: begin
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                result   <= '0;
                overflow <= 1'b0;
              end
            endcase
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ADDSUB: begin
          result   <= {{(N-1){1'b0}}, add_c, add_s};
          overflow <= add_ovf;
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        MUL: begin
          acc   <= acc_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          // Last iteration: the product is the freshly shifted {ACC, Q}
          if (cnt == CNT_W'(N-1)) begin
            result   <= {acc_next, q_next};
            overflow <= 1'b0;
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
